bp_resolve_update: RTL and testbench

- Feedback end of the branch-prediction protocol. The BP stage produces the predicted-taken bit, the PHT index, the predicted next PC and the current PC, and these travel down the pipeline.
- This block receives those same fields back from execute together with the resolved outcome. It trains the gshare PHT of 2-bit counters, maintains and recovers the GHR, and raises a registered mispredict/redirect.
- It also serves the BP-stage PHT lookup, so it owns the predictor state end to end.

---
 rtl/bp_resolve_update.sv | 109 ++++++++++
 tb/tb_bp_resolve_update.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/bp_resolve_update.sv
// gshare predictor state owner: serves the BP-stage PHT lookup, trains the 2-bit
// counters from resolved branches, keeps the speculative GHR and raises redirects.
module bp_resolve_update #(
   parameter int GHR_WIDTH  = 10,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  lookup_valid,
   input  logic                  lookup_is_branch,
   input  logic [ADDR_WIDTH-1:0] lookup_pc,
   output logic                  lookup_taken,
   output logic [GHR_WIDTH-1:0]  lookup_pht_index,
   input  logic                  resolve_valid,
   input  logic                  resolve_is_branch,
   input  logic                  resolve_predicted_taken,
   input  logic                  resolve_actual_taken,
   input  logic [GHR_WIDTH-1:0]  resolve_pht_index,
   input  logic [ADDR_WIDTH-1:0] resolve_pc,
   input  logic [ADDR_WIDTH-1:0] resolve_predicted_pc,
   input  logic [ADDR_WIDTH-1:0] resolve_target_pc,
   output logic                  mispredict,
   output logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic                  init_busy
);

   localparam int DEPTH = 1 << GHR_WIDTH;

   typedef enum logic {INIT, RUN} state_t;

   state_t               state;
   logic [1:0]           pht [DEPTH];
   logic [GHR_WIDTH-1:0] ghr;
   logic [GHR_WIDTH-1:0] init_ptr;
   logic [GHR_WIDTH-1:0] rec_ghr;
   logic [1:0]           cur_ctr;
   logic [1:0]           next_ctr;
   logic                 in_run;
   logic                 do_resolve;
   logic                 do_train;
   logic                 is_mispredict;
   logic                 unused_ok;

   assign in_run           = (state == RUN);
   assign init_busy        = ~in_run;
   assign lookup_pht_index = ghr ^ lookup_pc[GHR_WIDTH+1:2];
   assign lookup_taken     = in_run & pht[lookup_pht_index][1];

   assign do_resolve    = in_run & resolve_valid;
   assign do_train      = do_resolve & resolve_is_branch;
   assign is_mispredict = do_resolve & (resolve_predicted_pc != resolve_target_pc);
   // The returned index was formed as ghr ^ pc, so XOR with the pc again recovers
   // the history that was live when the branch was predicted.
   assign rec_ghr       = resolve_pht_index ^ resolve_pc[GHR_WIDTH+1:2];
   assign cur_ctr       = pht[resolve_pht_index];

   assign unused_ok = ^{resolve_predicted_taken, lookup_pc[1:0], resolve_pc[1:0],
                        lookup_pc[ADDR_WIDTH-1:GHR_WIDTH+2], resolve_pc[ADDR_WIDTH-1:GHR_WIDTH+2]};

   always_comb begin
      next_ctr = cur_ctr;
      if (resolve_actual_taken) begin
         if (cur_ctr != 2'b11) next_ctr = cur_ctr + 2'b01;
      end else begin
         if (cur_ctr != 2'b00) next_ctr = cur_ctr - 2'b01;
      end
   end

   // Counter array has no reset; the INIT sweep is what clears it.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (!in_run) begin
            pht[init_ptr] <= 2'b01;
         end else if (do_train) begin
            pht[resolve_pht_index] <= next_ctr;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= INIT;
         init_ptr    <= '0;
         ghr         <= '0;
         mispredict  <= 1'b0;
         redirect_pc <= '0;
      end else begin
         mispredict <= is_mispredict;
         if (is_mispredict) redirect_pc <= resolve_target_pc;
         case (state)
            INIT: begin
               init_ptr <= init_ptr + GHR_WIDTH'(1);
               if (init_ptr == '1) state <= RUN;
            end
            RUN: begin
               // Recovery wins over a same-cycle speculative shift.
               if (is_mispredict) begin
                  ghr <= resolve_is_branch ? {rec_ghr[GHR_WIDTH-2:0], resolve_actual_taken}
                                           : rec_ghr;
               end else if (lookup_valid && lookup_is_branch) begin
                  ghr <= {ghr[GHR_WIDTH-2:0], lookup_taken};
               end
            end
            default: state <= INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_bp_resolve_update.sv
// Bench for bp_resolve_update at GHR_WIDTH=4: directed vector table, init/reset
// sequences and random traffic against an integer-level predictor model.
module tb_bp_resolve_update;

   localparam int W = 4;
   localparam int A = 32;
   localparam int N = 1 << W;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          lookup_valid = 1'b0, lookup_is_branch = 1'b0;
   logic [A-1:0]  lookup_pc = '0;
   logic          lookup_taken;
   logic [W-1:0]  lookup_pht_index;
   logic          resolve_valid = 1'b0, resolve_is_branch = 1'b0;
   logic          resolve_predicted_taken = 1'b0, resolve_actual_taken = 1'b0;
   logic [W-1:0]  resolve_pht_index = '0;
   logic [A-1:0]  resolve_pc = '0, resolve_predicted_pc = '0, resolve_target_pc = '0;
   logic          mispredict;
   logic [A-1:0]  redirect_pc;
   logic          init_busy;

   int checks = 0;
   int errors = 0;

   bp_resolve_update #(.GHR_WIDTH(W), .ADDR_WIDTH(A)) dut (
      .clk(clk), .rst(rst),
      .lookup_valid(lookup_valid), .lookup_is_branch(lookup_is_branch), .lookup_pc(lookup_pc),
      .lookup_taken(lookup_taken), .lookup_pht_index(lookup_pht_index),
      .resolve_valid(resolve_valid), .resolve_is_branch(resolve_is_branch),
      .resolve_predicted_taken(resolve_predicted_taken), .resolve_actual_taken(resolve_actual_taken),
      .resolve_pht_index(resolve_pht_index), .resolve_pc(resolve_pc),
      .resolve_predicted_pc(resolve_predicted_pc), .resolve_target_pc(resolve_target_pc),
      .mispredict(mispredict), .redirect_pc(redirect_pc), .init_busy(init_busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic rst, lv, lb;
      logic [A-1:0] lpc;
      logic rv, rb, rpt, rat;
      logic [W-1:0] ridx;
      logic [A-1:0] rpc, rppc, rtpc;
      logic exp_taken;
      logic [W-1:0] exp_idx;
      logic exp_mp;
      logic [A-1:0] exp_redirect;
   } vec_t;

   // Predictor model: counters as integers 0..3, history as an integer 0..N-1.
   int          m_pht [N];
   int          m_ghr = 0;
   int          m_left = 0;
   bit          m_known = 0;
   bit          m_mp = 0;
   logic [A-1:0] m_redir = '0;

   function automatic vec_t mk(logic r, logic lv, logic lb, logic [A-1:0] lpc,
                               logic rv, logic rb, logic rpt, logic rat, logic [W-1:0] ridx,
                               logic [A-1:0] rpc, logic [A-1:0] rppc, logic [A-1:0] rtpc,
                               logic etk, logic [W-1:0] eidx, logic emp, logic [A-1:0] ered);
      vec_t v;
      v.rst = r; v.lv = lv; v.lb = lb; v.lpc = lpc;
      v.rv = rv; v.rb = rb; v.rpt = rpt; v.rat = rat; v.ridx = ridx;
      v.rpc = rpc; v.rppc = rppc; v.rtpc = rtpc;
      v.exp_taken = etk; v.exp_idx = eidx; v.exp_mp = emp; v.exp_redirect = ered;
      return v;
   endfunction

   function automatic int pcBits(logic [A-1:0] pc);
      return int'((pc >> 2) % N);
   endfunction

   task automatic checkOutput(string name, logic [A-1:0] act, logic [A-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input vec_t v, input bit use_exp);
      int idx;
      bit tk;
      bit mpc;
      int rec;
      rst = v.rst; lookup_valid = v.lv; lookup_is_branch = v.lb; lookup_pc = v.lpc;
      resolve_valid = v.rv; resolve_is_branch = v.rb; resolve_predicted_taken = v.rpt;
      resolve_actual_taken = v.rat; resolve_pht_index = v.ridx; resolve_pc = v.rpc;
      resolve_predicted_pc = v.rppc; resolve_target_pc = v.rtpc;
      #1;
      idx = m_ghr ^ pcBits(v.lpc);
      tk  = (m_left == 0) && (m_pht[idx] >= 2);
      if (m_known) begin
         checkOutput("lookup_idx", A'(lookup_pht_index), A'(idx));
         checkOutput("lookup_taken", A'(lookup_taken), A'(tk));
      end
      if (use_exp) begin
         checkOutput("tbl_idx", A'(lookup_pht_index), A'(v.exp_idx));
         checkOutput("tbl_taken", A'(lookup_taken), A'(v.exp_taken));
      end
      @(posedge clk);
      if (v.rst) begin
         m_ghr = 0; m_mp = 0; m_redir = '0; m_left = N; m_known = 1;
      end else if (m_left > 0) begin
         m_pht[N - m_left] = 1;
         m_left--;
         m_mp = 0;
      end else begin
         mpc = v.rv && (v.rppc != v.rtpc);
         if (v.rv && v.rb)
            m_pht[v.ridx] = v.rat ? ((m_pht[v.ridx] < 3) ? m_pht[v.ridx] + 1 : 3)
                                  : ((m_pht[v.ridx] > 0) ? m_pht[v.ridx] - 1 : 0);
         m_mp = mpc;
         if (mpc) begin
            m_redir = v.rtpc;
            rec = int'(v.ridx) ^ pcBits(v.rpc);
            m_ghr = v.rb ? (rec * 2 + int'(v.rat)) % N : rec;
         end else if (v.lv && v.lb) begin
            m_ghr = (m_ghr * 2 + int'(tk)) % N;
         end
      end
      #1;
      checkOutput("mispredict", A'(mispredict), A'(m_mp));
      checkOutput("redirect_pc", redirect_pc, m_redir);
      checkOutput("init_busy", A'(init_busy), A'(m_left > 0));
      if (use_exp) begin
         checkOutput("tbl_mispredict", A'(mispredict), A'(v.exp_mp));
         checkOutput("tbl_redirect", redirect_pc, v.exp_redirect);
      end
   endtask

   // Reset for one cycle, then idle through INIT while throwing mispredicting
   // resolves at it; INIT must last exactly N cycles and ignore them.
   task automatic runInit(string tag);
      vec_t v;
      int n;
      applyStimulus(mk(1,0,0,0, 0,0,0,0,0, 0,0,0, 0,0,0,0), 0);
      checkOutput({tag, "_busy_after_rst"}, A'(init_busy), A'(1));
      checkOutput({tag, "_mp_after_rst"}, A'(mispredict), A'(0));
      checkOutput({tag, "_redirect_after_rst"}, redirect_pc, '0);
      n = 0;
      v = mk(0,1,1,32'h14, 1,1,1,1,4'd5, 32'h40,32'h44,32'h300, 0,5,0,0);
      while (init_busy === 1'b1 && n < 200) begin
         applyStimulus(v, 1);
         n++;
      end
      checkOutput({tag, "_init_cycles"}, A'(n), A'(N));
      for (int i = 0; i < N; i++) begin
         applyStimulus(mk(0,0,0,A'(i*4), 0,0,0,0,0, 0,0,0, 0,W'(i),0,0), 1);
      end
   endtask

   vec_t tbl [20];
   vec_t rv;

   initial begin
      for (int i = 0; i < N; i++) m_pht[i] = -1;

      tbl[0]  = mk(0,1,0,32'h14, 1,1,1,1,4'd5, 32'h100,32'h104,32'h104, 0,4'd5,0,32'h0);
      tbl[1]  = mk(0,1,0,32'h14, 1,1,1,1,4'd5, 32'h100,32'h104,32'h104, 1,4'd5,0,32'h0);
      tbl[2]  = mk(0,1,0,32'h14, 1,1,1,1,4'd5, 32'h100,32'h104,32'h104, 1,4'd5,0,32'h0);
      tbl[3]  = mk(0,1,0,32'h14, 1,1,1,1,4'd5, 32'h100,32'h104,32'h104, 1,4'd5,0,32'h0);
      tbl[4]  = mk(0,1,0,32'h14, 1,1,0,0,4'd5, 32'h100,32'h104,32'h104, 1,4'd5,0,32'h0);
      tbl[5]  = mk(0,1,0,32'h14, 1,1,0,0,4'd5, 32'h100,32'h104,32'h104, 1,4'd5,0,32'h0);
      tbl[6]  = mk(0,1,0,32'h14, 0,0,0,0,4'd0, 32'h0,32'h0,32'h0,       0,4'd5,0,32'h0);
      tbl[7]  = mk(0,1,0,32'h0,  1,1,1,1,4'd5, 32'h100,32'h104,32'h104, 0,4'd0,0,32'h0);
      tbl[8]  = mk(0,1,1,32'h14, 0,0,0,0,4'd0, 32'h0,32'h0,32'h0,       1,4'd5,0,32'h0);
      tbl[9]  = mk(0,1,1,32'h10, 0,0,0,0,4'd0, 32'h0,32'h0,32'h0,       1,4'd5,0,32'h0);
      tbl[10] = mk(0,1,1,32'h18, 0,0,0,0,4'd0, 32'h0,32'h0,32'h0,       1,4'd5,0,32'h0);
      tbl[11] = mk(0,1,0,32'h0,  0,0,0,0,4'd0, 32'h0,32'h0,32'h0,       0,4'd7,0,32'h0);
      tbl[12] = mk(0,1,1,32'h0,  0,0,0,0,4'd0, 32'h0,32'h0,32'h0,       0,4'd7,0,32'h0);
      tbl[13] = mk(0,1,1,32'h2C, 1,1,1,1,4'd3, 32'h40,32'h44,32'h80,    1,4'd5,1,32'h80);
      tbl[14] = mk(0,0,0,32'h0,  0,0,0,0,4'd0, 32'h0,32'h0,32'h0,       0,4'd7,0,32'h80);
      tbl[15] = mk(0,0,0,32'h0,  1,0,0,0,4'd0, 32'h0,32'h10,32'h100,    0,4'd7,1,32'h100);
      tbl[16] = mk(0,0,0,32'h0,  1,0,0,0,4'd2, 32'h4,32'h10,32'h200,    0,4'd0,1,32'h200);
      tbl[17] = mk(0,0,0,32'h0,  0,0,0,0,4'd0, 32'h0,32'h0,32'h0,       1,4'd3,0,32'h200);
      tbl[18] = mk(0,0,0,32'h0,  1,1,1,0,4'd3, 32'h44,32'h48,32'h48,    1,4'd3,0,32'h200);
      tbl[19] = mk(0,0,0,32'h0,  0,0,0,0,4'd0, 32'h0,32'h0,32'h0,       0,4'd3,0,32'h200);

      @(negedge clk);
      runInit("first");
      for (int i = 0; i < 20; i++) applyStimulus(tbl[i], 1);

      // Random traffic; mispredicts about half the time a resolve is valid.
      for (int i = 0; i < 400; i++) begin
         rv.rst  = 1'b0;
         rv.lv   = 1'($urandom);
         rv.lb   = 1'($urandom);
         rv.lpc  = A'($urandom);
         rv.rv   = 1'($urandom);
         rv.rb   = ($urandom_range(0, 3) != 0);
         rv.rpt  = 1'($urandom);
         rv.rat  = 1'($urandom);
         rv.ridx = W'($urandom);
         rv.rpc  = A'($urandom);
         rv.rtpc = A'($urandom);
         rv.rppc = $urandom_range(0, 1) ? rv.rtpc : A'($urandom);
         applyStimulus(rv, 0);
      end

      // Saturate entry 5, then reset mid-run: the sweep must bring it back to 01.
      for (int i = 0; i < 3; i++)
         applyStimulus(mk(0,0,0,0, 1,1,1,1,4'd5, 32'h0,32'h8,32'h8, 0,0,0,0), 0);
      runInit("second");
      applyStimulus(mk(0,0,0,32'h14, 1,1,1,1,4'd5, 32'h0,32'h8,32'h8, 0,4'd5,0,32'h0), 1);
      applyStimulus(mk(0,0,0,32'h14, 0,0,0,0,4'd0, 32'h0,32'h0,32'h0, 1,4'd5,0,32'h0), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
